// File: rtl/sof_frame_timer.sv
// SOF frame timer, USB frame number and the one-shot first-SOF sync enable.
// Defining SOF_FRAME_INTR_EN builds the frameIntr/frameRollIntr pulse logic.
module sof_frame_timer #(
    parameter logic [15:0] SYNC_DELAY = 16'd48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SOFEnable,
    input  logic        SOFTimerClr,
    input  logic        SOFSent,
    input  logic [10:0] frameNumIn,
    input  logic        frameNumWEn,
    input  logic        overrunClr,
    output logic [15:0] SOFTimer,
    output logic [10:0] frameNum,
    output logic        SOFSyncEn,
    output logic        timerOverrun,
    output logic        frameIntr,
    output logic        frameRollIntr
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SYNC, ST_RUN} syncState_t;

    syncState_t  state;
    logic [15:0] syncCnt;

    always_ff @(posedge clk) begin
        if (rst)
            SOFTimer <= '0;
        else if (SOFTimerClr)
            SOFTimer <= '0;
        else if (SOFTimer != 16'hffff)
            SOFTimer <= SOFTimer + 16'd1;
    end

    // Only the fffe->ffff step sets the flag, so clearing it while saturated sticks.
    always_ff @(posedge clk) begin
        if (rst)
            timerOverrun <= 1'b0;
        else if (!SOFTimerClr && SOFTimer == 16'hfffe)
            timerOverrun <= 1'b1;
        else if (overrunClr)
            timerOverrun <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            frameNum <= '0;
        else if (frameNumWEn)
            frameNum <= frameNumIn;
        else if (SOFSent)
            frameNum <= frameNum + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || !SOFEnable) begin
            state     <= ST_IDLE;
            syncCnt   <= '0;
            SOFSyncEn <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_WAIT;
                    syncCnt <= '0;
                end
                ST_WAIT: begin
                    if (syncCnt == SYNC_DELAY - 16'd1) begin
                        state     <= ST_SYNC;
                        SOFSyncEn <= 1'b1;
                    end else begin
                        syncCnt <= syncCnt + 16'd1;
                    end
                end
                ST_SYNC: begin
                    if (SOFTimerClr) begin
                        state     <= ST_RUN;
                        SOFSyncEn <= 1'b0;
                    end
                end
                ST_RUN:  SOFSyncEn <= 1'b0;
                default: begin
                    state     <= ST_IDLE;
                    SOFSyncEn <= 1'b0;
                end
            endcase
        end
    end

`ifdef SOF_FRAME_INTR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frameIntr     <= 1'b0;
            frameRollIntr <= 1'b0;
        end else begin
            frameIntr     <= SOFSent;
            frameRollIntr <= SOFSent && !frameNumWEn && (frameNum == 11'h7ff);
        end
    end
`else
    assign frameIntr     = 1'b0;
    assign frameRollIntr = 1'b0;
`endif

endmodule

// File: tb/tb_sof_frame_timer.sv
// Directed bench for sof_frame_timer: a count-based reference model checked
// every cycle, plus literal expectations at the points the test plan names.
module tb_sof_frame_timer;
    localparam int SD = 16;

    logic        clk = 1'b0;
    logic        rst, SOFEnable, SOFTimerClr, SOFSent, frameNumWEn, overrunClr;
    logic [10:0] frameNumIn;
    logic [15:0] SOFTimer;
    logic [10:0] frameNum;
    logic        SOFSyncEn, timerOverrun, frameIntr, frameRollIntr;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    // model state
    int mTimer, mFrame, mEnRun;
    bit mOvr, mSync, mDone, mIntr, mRoll;

    sof_frame_timer #(.SYNC_DELAY(16'(SD))) dut (
        .clk(clk), .rst(rst), .SOFEnable(SOFEnable), .SOFTimerClr(SOFTimerClr),
        .SOFSent(SOFSent), .frameNumIn(frameNumIn), .frameNumWEn(frameNumWEn),
        .overrunClr(overrunClr), .SOFTimer(SOFTimer), .frameNum(frameNum),
        .SOFSyncEn(SOFSyncEn), .timerOverrun(timerOverrun), .frameIntr(frameIntr),
        .frameRollIntr(frameRollIntr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sync enable is a function of how long SOFEnable has been
    // continuously high, and whether a timer clear has already consumed it.
    always @(posedge clk) begin
        if (rst) begin
            mTimer = 0; mOvr = 0; mFrame = 0; mEnRun = 0;
            mSync = 0; mDone = 0; mIntr = 0; mRoll = 0;
        end else begin
            mOvr = (!SOFTimerClr && mTimer == 65534) ? 1'b1 : (overrunClr ? 1'b0 : mOvr);
            mTimer = SOFTimerClr ? 0 : (mTimer < 65535 ? mTimer + 1 : 65535);
`ifdef SOF_FRAME_INTR_EN
            mIntr = SOFSent;
            mRoll = SOFSent && !frameNumWEn && mFrame == 2047;
`endif
            if (frameNumWEn) mFrame = int'(frameNumIn);
            else if (SOFSent) mFrame = (mFrame + 1) % 2048;
            if (!SOFEnable) begin
                mEnRun = 0; mSync = 0; mDone = 0;
            end else begin
                if (mEnRun < 1000000) mEnRun++;
                if (mSync && SOFTimerClr) begin
                    mSync = 0; mDone = 1;
                end else begin
                    mSync = !mDone && (mEnRun >= SD + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            cmp("SOFTimer", int'(SOFTimer), mTimer);
            cmp("frameNum", int'(frameNum), mFrame);
            cmp("SOFSyncEn", int'(SOFSyncEn), int'(mSync));
            cmp("timerOverrun", int'(timerOverrun), int'(mOvr));
            cmp("frameIntr", int'(frameIntr), int'(mIntr));
            cmp("frameRollIntr", int'(frameRollIntr), int'(mRoll));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int intrExp;

    initial begin
`ifdef SOF_FRAME_INTR_EN
        intrExp = 1;
`else
        intrExp = 0;
`endif
        rst = 1; SOFEnable = 0; SOFTimerClr = 0; SOFSent = 0;
        frameNumWEn = 0; overrunClr = 0; frameNumIn = '0;
        step(2);
        chk = 1'b1;
        cmp("reset timer", int'(SOFTimer), 0);
        cmp("reset syncEn", int'(SOFSyncEn), 0);
        rst = 0;

        // idle: timer free-runs with SOF disabled
        step(100);
        cmp("idle timer", int'(SOFTimer), 100);
        cmp("idle frameNum", int'(frameNum), 0);
        cmp("idle syncEn", int'(SOFSyncEn), 0);

        // saturation; clear requested on the overrun step itself (set wins)
        step(65532 - 100);
        cmp("timer fffc", int'(SOFTimer), 16'hfffc);
        overrunClr = 1;
        step(3);
        overrunClr = 0;
        cmp("sat timer", int'(SOFTimer), 16'hffff);
        cmp("overrun set", int'(timerOverrun), 1);
        step(5);
        cmp("timer holds", int'(SOFTimer), 16'hffff);
        overrunClr = 1; step(1); overrunClr = 0;
        cmp("overrun cleared", int'(timerOverrun), 0);
        step(10);
        cmp("overrun stays 0", int'(timerOverrun), 0);
        SOFTimerClr = 1; step(1); SOFTimerClr = 0;
        cmp("timer cleared", int'(SOFTimer), 0);

        // sync run 1; SOF pulses in WAIT have no FSM effect
        SOFEnable = 1;
        step(5);
        SOFTimerClr = 1; step(1); SOFTimerClr = 0;
        step(10);
        cmp("syncEn before delay", int'(SOFSyncEn), 0);
        step(1);
        cmp("syncEn at delay", int'(SOFSyncEn), 1);
        step(3);
        cmp("syncEn held", int'(SOFSyncEn), 1);
        SOFTimerClr = 1; step(1); SOFTimerClr = 0;
        cmp("syncEn falls", int'(SOFSyncEn), 0);
        cmp("timer 0 on clr", int'(SOFTimer), 0);
        SOFTimerClr = 1; SOFSent = 1; step(1); SOFTimerClr = 0; SOFSent = 0;
        step(30);
        cmp("RUN stays low", int'(SOFSyncEn), 0);

        // sync run 2: enable dropped before the delay expires
        SOFEnable = 0; step(2);
        SOFEnable = 1; step(10);
        SOFEnable = 0; step(30);
        cmp("aborted sync", int'(SOFSyncEn), 0);

        // frame number wrap
        frameNumWEn = 1; frameNumIn = 11'h7fe; step(1); frameNumWEn = 0;
        cmp("frame load", int'(frameNum), 11'h7fe);
        SOFSent = 1; step(1); SOFSent = 0;
        cmp("frame 7ff", int'(frameNum), 11'h7ff);
        cmp("frameIntr 1st", int'(frameIntr), intrExp);
        cmp("no roll yet", int'(frameRollIntr), 0);
        SOFSent = 1; step(1); SOFSent = 0;
        cmp("frame wrap", int'(frameNum), 0);
        cmp("frameIntr 2nd", int'(frameIntr), intrExp);
        cmp("roll on wrap", int'(frameRollIntr), intrExp);
        step(1);
        cmp("roll one-shot", int'(frameRollIntr), 0);
        frameNumWEn = 1; frameNumIn = 11'h000; step(1); frameNumWEn = 0;
        cmp("load 0 no roll", int'(frameRollIntr), 0);

        // load beats increment
        frameNumWEn = 1; frameNumIn = 11'h123; SOFSent = 1; step(1);
        frameNumWEn = 0; SOFSent = 0;
        cmp("load wins", int'(frameNum), 11'h123);

        // reset while in SYNC with frameNum 5, enable held through reset
        SOFEnable = 1;
        frameNumWEn = 1; frameNumIn = 11'd5; step(1); frameNumWEn = 0;
        step(SD + 2);
        cmp("pre-reset sync", int'(SOFSyncEn), 1);
        cmp("pre-reset frame", int'(frameNum), 5);
        rst = 1; SOFSent = 1; overrunClr = 1; step(1);
        SOFSent = 0; overrunClr = 0;
        cmp("rst timer", int'(SOFTimer), 0);
        cmp("rst frame", int'(frameNum), 0);
        cmp("rst syncEn", int'(SOFSyncEn), 0);
        cmp("rst overrun", int'(timerOverrun), 0);
        rst = 0;
        step(SD);
        cmp("restart wait", int'(SOFSyncEn), 0);
        step(1);
        cmp("restart sync", int'(SOFSyncEn), 1);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sof_frame_timer.md
# sof_frame_timer

Frame-timing source for the USB host controller's SOF transmitter. It provides the free-running 16-bit SOF timer that the SOF transmitter compares against its near-time and frame-end thresholds. It keeps the 11-bit USB frame number, which advances on each sent SOF. It also generates the one-shot `SOFSyncEn` that lets the first SOF go out after software enables SOF generation. It sits directly upstream of the SOF transmitter: it consumes that block's `SOFTimerClr`/`SOFSent` pulses and feeds back `SOFTimer`/`SOFSyncEn`.

## Interface
Parameters:
- `SYNC_DELAY`, default 16'd48000: cycles `SOFEnable` must be continuously high before `SOFSyncEn` asserts (one 1 ms frame at 48 MHz). Legal range is 1 to 65535.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `SOFEnable`  in  1  host-software SOF generation enable
- `SOFTimerClr`  in  1  single-cycle pulse from the SOF transmitter; zeroes the timer
- `SOFSent`  in  1  single-cycle pulse from the SOF transmitter; a SOF packet was issued
- `frameNumIn`  in  11  software frame-number load value
- `frameNumWEn`  in  1  load strobe for `frameNumIn`
- `overrunClr`  in  1  clears `timerOverrun`
- `SOFTimer`  out  16  frame timer
- `frameNum`  out  11  current USB frame number
- `SOFSyncEn`  out  1  one-shot sync enable to the SOF transmitter
- `timerOverrun`  out  1  sticky: the timer saturated without a clear
- `frameIntr`  out  1  pulse per sent SOF (see Configuration)
- `frameRollIntr`  out  1  pulse on frame-number wrap (see Configuration)

## Operation
- All outputs are registered. Every output resets to 0.
- **SOFTimer** free-runs regardless of `SOFEnable`.
  - `SOFTimerClr` = 1: next value is 0.
  - Else, if `SOFTimer` == 16'hffff: hold (saturate).
  - Else: increment by 1.
- **timerOverrun**
  - Set when the timer steps from 16'hfffe to 16'hffff.
  - Cleared by `overrunClr`.
  - If set and clear occur in the same cycle, set wins.
  - A clear while the timer is saturated succeeds. The flag does not re-set until the timer is cleared and overruns again.
- **frameNum**
  - `frameNumWEn` loads `frameNumIn`.
  - Else `SOFSent` increments it modulo 2048 (11'h7ff → 11'h000).
  - If `frameNumWEn` and `SOFSent` occur in the same cycle, the load wins and no increment happens.
- **Sync FSM**, 2-bit state, 16-bit counter `syncCnt`:
  - IDLE: `SOFSyncEn`=0, `syncCnt`=0. `SOFEnable`=1 → WAIT.
  - WAIT: `syncCnt` increments each cycle. When `syncCnt` == `SYNC_DELAY`-1 → SYNC, with `SOFSyncEn` set to 1.
  - SYNC: `SOFSyncEn` held at 1. `SOFTimerClr`=1 → RUN, with `SOFSyncEn` set to 0.
  - RUN: `SOFSyncEn`=0; timer-driven operation only.
  - From any state, `SOFEnable`=0 → IDLE, with `SOFSyncEn` and `syncCnt` zeroed the next cycle. This takes priority over every other transition.
  - Re-enabling restarts the full `SYNC_DELAY` wait.

## Timing
- An input sampled at edge n is reflected on outputs after edge n. Latency is one cycle for every path.
- `SOFSyncEn` rises exactly `SYNC_DELAY` cycles after the first edge that samples `SOFEnable`=1.
- `SOFSyncEn` falls the cycle after `SOFTimerClr` is sampled in SYNC.
- In RUN, `SOFTimerClr` and `SOFSent` have no FSM effect.
- `rst` mid-operation returns every register (timer, frame number, FSM, flags) to 0 on the next edge. All other inputs are ignored while `rst`=1.

## Configuration
- With `SOF_FRAME_INTR_EN` defined:
  - `frameIntr` pulses one cycle for each `SOFSent`.
  - `frameRollIntr` pulses one cycle when an increment wraps `frameNum` from 11'h7ff to 11'h000. A `frameNumWEn` load of 0 does not trigger it.
  - Both pulses coincide with the updated `frameNum`.
- Without the macro: both ports remain present, are tied to constant 0, and no interrupt logic is synthesized.

## Test plan
- Reset, then 100 idle cycles with `SOFEnable`=0 → `SOFTimer`=100, `frameNum`=0, `SOFSyncEn`=0, all flags 0.
- `SYNC_DELAY`=16, `SOFEnable` raised at cycle 0 → `SOFSyncEn`=1 from cycle 16. Pulse `SOFTimerClr` at cycle 20 → `SOFSyncEn`=0 and `SOFTimer`=0 at cycle 21. Drop `SOFEnable` at cycle 10 in a second run → `SOFSyncEn` never asserts.
- No `SOFTimerClr` for 65535 cycles after reset → `SOFTimer` holds 16'hffff and `timerOverrun`=1. `overrunClr` with the timer held → flag clears and stays 0 until a clear followed by a new overrun.
- Load `frameNumIn`=11'h7fe, then two `SOFSent` pulses → `frameNum` goes 7ff then 000. With the macro, `frameIntr` pulses twice and `frameRollIntr` pulses once on the wrap.
- `frameNumWEn`(11'h123) and `SOFSent` in the same cycle → `frameNum`=11'h123, not 124.
- Assert `rst` while in SYNC with `frameNum`=5 → the next cycle shows all outputs 0. `SOFEnable` held at 1 through reset → a full `SYNC_DELAY` wait restarts.
